// File: rtl/fp_round_pack.sv
// fp_round_pack: final stage of the FP datapath. It takes a normalized,
// unrounded {sign, exponent, mantissa+GRS} triple, denormalizes tiny values,
// rounds to nearest even, and packs an IEEE-754 word with exception flags.
// The pipeline is fully pipelined with no backpressure. An operand sampled
// at edge k has its result presented after edge k+3.
//
// Ports
//   clk, rst     clock (rising edge); asynchronous active-high reset
//   start        operand valid
//   in_sign      result sign
//   in_exp       biased exponent, two's complement (EXP_W+2 bits)
//   in_man       {hidden, fraction, guard, round, sticky}
//   in_inv       in_man holds the one's complement of the magnitude
//   in_nan       force canonical quiet NaN
//   done         one-cycle pulse; res/flags valid
//   res          packed {sign, exp, fraction}; held between pulses
//   overflow     result rounded to infinity
//   underflow    tiny and inexact
//   inexact      guard/round/sticky bits were discarded
module fp_round_pack #(
  parameter  int DATA_W = 32,
  parameter  int EXP_W  = 8,
  localparam int F_W    = DATA_W - EXP_W - 1,
  localparam int MAN_W  = F_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_sign,
  input  logic [EXP_W+1:0]  in_exp,
  input  logic [MAN_W+2:0]  in_man,
  input  logic              in_inv,
  input  logic              in_nan,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);
  localparam int STAGES = 3;
  localparam int MW     = MAN_W + 3;
  // The extra bits leave room for in_exp at its maximum plus the rounding carry.
  localparam int EW     = EXP_W + 3;
  localparam logic [EW-1:0] E_INF = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W+1:0] exp;
    logic [MW-1:0]    man;
    logic             inv;
    logic             nan;
  } s0_t;

  typedef struct packed {
    logic          sign;
    logic          nan;
    logic          zero;
    logic          tiny;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
  } s1_t;

  typedef struct packed {
    logic           sign;
    logic           nan;
    logic           zero;
    logic           tiny;
    logic           inx;
    logic [EW-1:0]  e;
    logic [F_W-1:0] frac;
  } s2_t;

  logic [STAGES:0]   vld_pipe;
  s0_t               s0_q, s0_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  // Input capture.
  always_comb begin
    s0_d.sign = in_sign;
    s0_d.exp  = in_exp;
    s0_d.man  = in_man;
    s0_d.inv  = in_inv;
    s0_d.nan  = in_nan;
  end

  // S1: restore the magnitude, then denormalize tiny values.
  logic [MW-1:0] m_full, m_sh;
  logic [EW-1:0] exp_x, sh;
  logic          tiny, lost;
  always_comb begin
    m_full = s0_q.inv ? ~s0_q.man : s0_q.man;
    exp_x  = {s0_q.exp[EXP_W+1], s0_q.exp};
    tiny   = s0_q.exp[EXP_W+1] | (s0_q.exp == '0);
    // The shift amount is 1-exp. Shifts of MW or more clear m_sh entirely,
    // so no explicit clamp is needed and every set bit lands in sticky.
    sh     = EW'(1) - exp_x;
    m_sh   = m_full >> sh;
    lost   = ((m_full >> sh) << sh) != m_full;
    s1_d.sign = s0_q.sign;
    s1_d.nan  = s0_q.nan;
    s1_d.zero = (m_full == '0);
    s1_d.tiny = tiny;
    if (tiny) begin
      s1_d.e = '0;
      s1_d.m = m_sh | MW'(lost);
    end else begin
      s1_d.e = {1'b0, s0_q.exp};
      s1_d.m = m_full;
    end
  end

  // S2: round to nearest, ties to even.
  logic [MAN_W:0] mr;
  logic [EW-1:0]  e2;
  logic           g, rs, up;
  always_comb begin
    g  = s1_q.m[2];
    rs = |s1_q.m[1:0];
    up = g & (rs | s1_q.m[3]);
    mr = {1'b0, s1_q.m[MW-1:3]} + (MAN_W+1)'(up);
    e2 = s1_q.e;
    if (mr[MAN_W]) begin
      mr = mr >> 1;
      e2 = s1_q.e + EW'(1);
    end
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (e2 == '0 && mr[MAN_W-1]) e2 = EW'(1);
    s2_d.sign = s1_q.sign;
    s2_d.nan  = s1_q.nan;
    s2_d.zero = s1_q.zero;
    s2_d.tiny = s1_q.tiny;
    s2_d.inx  = g | rs;
    s2_d.e    = e2;
    s2_d.frac = mr[F_W-1:0];
  end

  // S3: special cases and packing.
  always_comb begin
    res_d = {s2_q.sign, s2_q.e[EXP_W-1:0], s2_q.frac};
    ovf_d = 1'b0;
    unf_d = s2_q.tiny & s2_q.inx;
    inx_d = s2_q.inx;
    if (s2_q.nan) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F_W-1){1'b0}}};
      unf_d = 1'b0;
      inx_d = 1'b0;
    end else if (s2_q.zero) begin
      res_d = {s2_q.sign, {(DATA_W-1){1'b0}}};
      unf_d = 1'b0;
      inx_d = 1'b0;
    end else if (s2_q.e >= E_INF) begin
      res_d = {s2_q.sign, {EXP_W{1'b1}}, {F_W{1'b0}}};
      ovf_d = 1'b1;
      unf_d = 1'b0;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], start};
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      // Outputs only move on a valid result so they hold between pulses.
      if (vld_pipe[STAGES-1]) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inx_q <= inx_d;
      end
    end
  end

  assign done      = vld_pipe[STAGES];
  assign res       = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Testbench for fp_round_pack (DATA_W=32, EXP_W=8). Stimulus pushes expected
// results into a queue. A negedge monitor pops an entry on each done pulse
// and compares the result, the flags and the latency.
module tb_fp_round_pack;
  logic        clk = 1'b0;
  logic        rst, start, in_sign, in_inv, in_nan;
  logic [9:0]  in_exp;
  logic [26:0] in_man;
  logic        done, overflow, underflow, inexact;
  logic [31:0] res;

  fp_round_pack #(.DATA_W(32), .EXP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_sign(in_sign), .in_exp(in_exp),
    .in_man(in_man), .in_inv(in_inv), .in_nan(in_nan), .done(done), .res(res),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    bit          ovf, unf, inx;
    int          cyc;
  } exp_t;

  exp_t sq[$];
  exp_t mon_x;
  int   nchk = 0, nfail = 0, cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t ek(input logic [31:0] r, input bit o, input bit u, input bit i);
    exp_t x;
    x.res = r; x.ovf = o; x.unf = u; x.inx = i; x.cyc = 0;
    return x;
  endfunction

  function automatic logic [26:0] mk(input bit h, input logic [22:0] f, input logic [2:0] grs);
    return {h, f, grs};
  endfunction

  // Reference model: the value is mag/8 units of the fraction LSB, computed
  // with integer division and remainders.
  function automatic exp_t model(input bit s, input int e, input logic [26:0] mag, input bit nan);
    exp_t   r;
    longint m, q, rem, ee;
    bit     tiny;
    int     sh;
    r = ek(32'h0, 0, 0, 0);
    if (nan) begin
      r.res = 32'h7FC00000;
      return r;
    end
    if (mag == 0) begin
      r.res = {s, 31'h0};
      return r;
    end
    m    = longint'(mag);
    tiny = (e <= 0);
    ee   = tiny ? 0 : e;
    if (tiny) begin
      sh = 1 - e;
      if (sh >= 40) m = 1;
      else begin
        q = m >> sh;
        m = q | ((m != (q << sh)) ? 64'd1 : 64'd0);
      end
    end
    q   = m / 8;
    rem = m % 8;
    r.inx = (rem != 0);
    if (rem > 4 || (rem == 4 && q % 2 == 1)) q++;
    if (q >= (64'd1 << 24)) begin
      q = q / 2;
      ee++;
    end
    if (ee == 0 && q >= (64'd1 << 23)) ee = 1;
    if (ee >= 255) begin
      r.res = {s, 8'hFF, 23'h0};
      r.ovf = 1;
      r.inx = 1;
    end else begin
      r.res = {s, 8'(ee), 23'(q)};
      r.unf = tiny && r.inx;
    end
    return r;
  endfunction

  task automatic drive(input bit s, input int e, input logic [26:0] mag, input bit inv,
                       input bit nan, input exp_t x);
    @(posedge clk); #1;
    in_sign = s;
    in_exp  = e[9:0];
    in_man  = inv ? ~mag : mag;
    in_inv  = inv;
    in_nan  = nan;
    start   = 1'b1;
    x.cyc   = cyc + 1;
    sq.push_back(x);
  endtask

  task automatic drive_rand();
    bit          s, inv, nan;
    int          e;
    logic [26:0] mag;
    s = 1'($urandom);
    case ($urandom_range(3))
      0: e = int'($urandom_range(60)) - 30;
      1: e = int'($urandom_range(254, 1));
      2: e = int'($urandom_range(320, 240));
      default: e = int'($signed(10'($urandom)));
    endcase
    mag     = 27'($urandom);
    mag[26] = ($urandom_range(7) != 0);
    if ($urandom_range(3) == 0) mag[2:0] = 3'b100;
    if ($urandom_range(15) == 0) mag = '0;
    inv = 1'($urandom);
    nan = ($urandom_range(15) == 0);
    drive(s, e, mag, inv, nan, model(s, e, mag, nan));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (sq.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d results still outstanding, expected 0", sq.size());
      sq.delete();
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!rst && done) begin
      if (sq.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL stray_done: done=1 with no result outstanding at cycle %0d", cyc);
      end else begin
        mon_x = sq.pop_front();
        chk("result", {res, overflow, underflow, inexact},
            {mon_x.res, mon_x.ovf, mon_x.unf, mon_x.inx});
        chk("latency", 64'(cyc - mon_x.cyc), 64'd3);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b1; in_sign = 1'b0; in_exp = 10'd127;
    in_man = mk(1'b1, 23'h0, 3'b000); in_inv = 1'b0; in_nan = 1'b0;
    #12;
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_res", 64'(res), 64'd0);
    chk("reset_flags", 64'({overflow, underflow, inexact}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    idle(6);

    // Directed cases, issued back-to-back.
    drive(0, 127, mk(1, 23'h000000, 3'b000), 0, 0, ek(32'h3F800000, 0, 0, 0));
    drive(0, 127, mk(1, 23'h000001, 3'b100), 0, 0, ek(32'h3F800002, 0, 0, 1));
    drive(0, 127, mk(1, 23'h000000, 3'b100), 0, 0, ek(32'h3F800000, 0, 0, 1));
    drive(0, 127, mk(1, 23'h7FFFFF, 3'b110), 0, 0, ek(32'h40000000, 0, 0, 1));
    drive(0, 254, mk(1, 23'h7FFFFF, 3'b100), 0, 0, ek(32'h7F800000, 1, 0, 1));
    drive(0, 300, mk(1, 23'h000000, 3'b000), 0, 0, ek(32'h7F800000, 1, 0, 1));
    drive(0, 0,   mk(1, 23'h000000, 3'b000), 0, 0, ek(32'h00400000, 0, 0, 0));
    drive(0, -30, mk(1, 23'h000000, 3'b000), 0, 0, ek(32'h00000000, 0, 1, 1));
    drive(0, -1,  mk(1, 23'h000000, 3'b000), 0, 0, ek(32'h00200000, 0, 0, 0));
    drive(0, 0,   mk(1, 23'h7FFFFF, 3'b111), 0, 0, ek(32'h00800000, 0, 1, 1));
    drive(0, 254, mk(1, 23'h7FFFFF, 3'b000), 0, 0, ek(32'h7F7FFFFF, 0, 0, 0));
    drive(1, 255, mk(1, 23'h000000, 3'b000), 0, 0, ek(32'hFF800000, 1, 0, 1));
    drive(1, 127, 27'h0,                     0, 0, ek(32'h80000000, 0, 0, 0));
    drive(0, 127, mk(1, 23'h000000, 3'b000), 1, 0, ek(32'h3F800000, 0, 0, 0));
    drive(1, 5,   mk(1, 23'h000123, 3'b101), 0, 1, ek(32'h7FC00000, 0, 0, 0));
    idle(1);
    drain();

    // Eight distinct operands with start held high.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] grs;
      grs = 3'(i);
      drive(0, 100 + i, mk(1, 23'(i * 3), grs), 0, 0,
            model(0, 100 + i, mk(1, 23'(i * 3), grs), 0));
    end
    idle(1);
    drain();

    // Random operands with occasional gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      drive_rand();
    end
    idle(1);
    drain();

    // Reset mid-stream: done drops at once, in-flight results are discarded.
    for (int i = 0; i < 6; i++) drive_rand();
    #1;
    chk("pre_reset_done", 64'(done), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_done", 64'(done), 64'd0);
    chk("async_reset_res", 64'(res), 64'd0);
    sq.delete();
    repeat (3) begin
      @(posedge clk); #1;
      in_man = 27'($urandom);
    end
    rst = 1'b0;
    start = 1'b0;
    idle(8);
    drive(0, 127, mk(1, 23'h000001, 3'b100), 0, 0, ek(32'h3F800002, 0, 0, 1));
    idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
